// File: rtl/dest_seq_ctrl_if.sv
// dest_seq_ctrl_if: instruction handshake between an instruction source and
// the destination-address sequencer.
//   instr_valid  source -> sequencer  instruction offered
//   instr_ready  sequencer -> source  sequencer can accept
//   instr_op     source -> sequencer  2'b00 PIM, 2'b01 MOV, 2'b1x reserved
//   instr_addr   source -> sequencer  base address (PIM) or move target (MOV)
//   instr_len    source -> sequencer  row count (PIM only)
interface dest_seq_ctrl_if #(
    parameter int unsigned N     = 10,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned OP_W = 2;

    logic             instr_valid;
    logic             instr_ready;
    logic [OP_W-1:0]  instr_op;
    logic [N-1:0]     instr_addr;
    logic [CNT_W-1:0] instr_len;

    modport master (
        output instr_valid,
        output instr_op,
        output instr_addr,
        output instr_len,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_addr,
        input  instr_len,
        output instr_ready
    );
endinterface

// File: rtl/dest_seq_ctrl.sv
// dest_seq_ctrl: upstream sequencer for the PIM destination-address register.
// Accepts one PIM or MOV instruction at a time and drives the destination
// register's D / MOV_in / PIM_load / Mov_load / Update_load inputs. A PIM
// instruction walks instr_len consecutive rows (one row_strobe each), then
// pulses done. Rejected instructions pulse err without leaving IDLE.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   instr         instruction handshake (slave side)
//   row_stall     array not ready for the next row
//   D, MOV_in     base / move address to the destination register
//   PIM_load, Mov_load, Update_load   destination register load controls
//   row_strobe    current destination row executes this cycle
//   cur_row       shadow of the destination register value
//   busy, done, err  status: not idle / completion pulse / reject pulse
//
// Build option: define DEST_SEQ_STALL_EN to honour row_stall; otherwise
// row_stall is ignored and STEP always advances.
module dest_seq_ctrl #(
    parameter int unsigned N     = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    dest_seq_ctrl_if.slave   instr,
    input  logic             row_stall,
    output logic [N-1:0]     D,
    output logic [N-1:0]     MOV_in,
    output logic             PIM_load,
    output logic             Mov_load,
    output logic             Update_load,
    output logic             row_strobe,
    output logic [N-1:0]     cur_row,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int unsigned OP_W   = 2;
    localparam logic [OP_W-1:0] OP_PIM = 2'b00;
    localparam logic [OP_W-1:0] OP_MOV = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_STEP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [N-1:0]     d_d, mov_d, cur_row_d;
    logic             err_d;
    logic             stall_c;

    // Stall qualification is a build-time option.
`ifdef DEST_SEQ_STALL_EN
    assign stall_c = row_stall;
`else
    logic unused_row_stall;
    assign unused_row_stall = row_stall;
    assign stall_c          = 1'b0;
`endif

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign instr.instr_ready = (state_q == S_IDLE) & ~rst;
    assign busy              = (state_q != S_IDLE);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            D           <= '0;
            MOV_in      <= '0;
            cur_row     <= '0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            D           <= d_d;
            MOV_in      <= mov_d;
            cur_row     <= cur_row_d;
            err         <= err_d;
        end
    end

    // Next-state, datapath update and strobe decode from registered state.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        d_d         = D;
        mov_d       = MOV_in;
        cur_row_d   = cur_row;
        err_d       = 1'b0;
        PIM_load    = 1'b0;
        Mov_load    = 1'b0;
        Update_load = 1'b0;
        row_strobe  = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr.instr_valid) begin
                    remaining_d = CNT_W'(instr.instr_len);
                    case (instr.instr_op)
                        OP_PIM: begin
                            d_d = N'(instr.instr_addr);
                            if (instr.instr_len == '0) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end
                        OP_MOV: begin
                            mov_d   = N'(instr.instr_addr);
                            state_d = S_MOVE;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                PIM_load  = 1'b1;
                cur_row_d = D;
                state_d   = S_STEP;
            end
            S_MOVE: begin
                Mov_load  = 1'b1;
                cur_row_d = MOV_in;
                state_d   = S_DONE;
            end
            S_STEP: begin
                if (!stall_c) begin
                    row_strobe  = 1'b1;
                    remaining_d = remaining_q - CNT_W'(1);
                    // The last row gets no update so the register stays on it.
                    if (remaining_q > CNT_W'(1)) begin
                        Update_load = 1'b1;
                        cur_row_d   = cur_row + N'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dest_seq_ctrl.sv
module tb_dest_seq_ctrl;
    localparam int unsigned N     = 10;
    localparam int unsigned CNT_W = 8;
`ifdef DEST_SEQ_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dest_seq_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

    logic         row_stall;
    logic [N-1:0] D, MOV_in, cur_row;
    logic         PIM_load, Mov_load, Update_load, row_strobe, busy, done, err;

    dest_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (bus),
        .row_stall   (row_stall),
        .D           (D),
        .MOV_in      (MOV_in),
        .PIM_load    (PIM_load),
        .Mov_load    (Mov_load),
        .Update_load (Update_load),
        .row_strobe  (row_strobe),
        .cur_row     (cur_row),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // {PIM_load, Mov_load, Update_load, row_strobe, done, err, busy, instr_ready}
    logic [7:0] obs;
    assign obs = {PIM_load, Mov_load, Update_load, row_strobe, done, err, busy, bus.instr_ready};

    int tests = 0;
    int fails = 0;
    logic [N-1:0] exp_rows[$];

    // Scoreboard: every strobed row must match the next expected row address.
    always @(negedge clk) begin
        if (row_strobe === 1'b1) begin
            tests++;
            if (exp_rows.size() == 0) begin
                fails++;
                $display("FAIL row_sb: unexpected strobe, cur_row=%h, none expected", cur_row);
            end else begin
                logic [N-1:0] e;
                e = exp_rows.pop_front();
                if (cur_row !== e) begin
                    fails++;
                    $display("FAIL row_sb: cur_row=%h expected %h", cur_row, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        row_stall = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_op = 2'b00;
        bus.instr_addr = '0;
        bus.instr_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (obs !== 8'b0000_0000 || D !== '0 || MOV_in !== '0 || cur_row !== '0) begin
            fails++;
            $display("FAIL reset_hold: obs=%b D=%h MOV_in=%h cur_row=%h expected all 0", obs, D, MOV_in, cur_row);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== 8'b0000_0001 || D !== '0 || MOV_in !== '0 || cur_row !== '0) begin
            fails++;
            $display("FAIL reset_release: obs=%b D=%h expected obs=00000001 regs 0", obs, D);
        end
    endtask

    // PIM run with an optional single stall cycle (0 = none).
    task automatic test_pim(input logic [N-1:0] addr, input int len, input int stall_cyc, input string name);
        bit stall_hit;
        int done_cyc;
        bit s, u;
        logic [7:0] exp;
        stall_hit = STALL_EN && stall_cyc >= 2 && stall_cyc <= len + 1;
        done_cyc  = len + 2 + (stall_hit ? 1 : 0);
        for (int i = 0; i < len; i++) exp_rows.push_back(N'(int'(addr) + i));
        tests++;
        if (bus.instr_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready0: instr_ready=%b expected 1", name, bus.instr_ready);
        end
        bus.instr_valid = 1'b1;
        bus.instr_op    = 2'b00;
        bus.instr_addr  = addr;
        bus.instr_len   = CNT_W'(len);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.instr_valid = 1'b0;
            row_stall = (c == stall_cyc);
            @(negedge clk);
            s   = (c >= 2) && (c < done_cyc) && !(stall_hit && c == stall_cyc);
            u   = s && (c != done_cyc - 1);
            exp = {c == 1, 1'b0, u, s, c == done_cyc, 1'b0, c <= done_cyc, c > done_cyc};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s cycle %0d: obs=%b expected %b", name, c, obs, exp);
            end
            if (c == 1) begin
                tests++;
                if (D !== addr) begin
                    fails++;
                    $display("FAIL %s D: D=%h expected %h", name, D, addr);
                end
            end
        end
        row_stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] tbl [1:7];
        tbl[1] = 8'b0100_0010;
        tbl[2] = 8'b0000_1010;
        tbl[3] = 8'b0000_0001;
        tbl[4] = 8'b1000_0010;
        tbl[5] = 8'b0001_0010;
        tbl[6] = 8'b0000_1010;
        tbl[7] = 8'b0000_0001;
        exp_rows.push_back(10'h020);
        tests++;
        if (bus.instr_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b ready0: instr_ready=%b expected 1", bus.instr_ready);
        end
        bus.instr_valid = 1'b1;
        bus.instr_op    = 2'b01;
        bus.instr_addr  = 10'h155;
        bus.instr_len   = 8'd9;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus.instr_op   = 2'b00;
                bus.instr_addr = 10'h020;
                bus.instr_len  = 8'd1;
            end
            if (c == 4) bus.instr_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (obs !== tbl[c]) begin
                fails++;
                $display("FAIL b2b cycle %0d: obs=%b expected %b", c, obs, tbl[c]);
            end
            if (c == 1) begin
                tests++;
                if (MOV_in !== 10'h155) begin
                    fails++;
                    $display("FAIL b2b MOV_in: %h expected 155", MOV_in);
                end
            end
            if (c == 2) begin
                tests++;
                if (cur_row !== 10'h155) begin
                    fails++;
                    $display("FAIL b2b cur_row_mov: %h expected 155", cur_row);
                end
            end
            if (c == 4) begin
                tests++;
                if (D !== 10'h020) begin
                    fails++;
                    $display("FAIL b2b D: %h expected 020", D);
                end
            end
        end
    endtask

    task automatic test_reject(input logic [1:0] op, input int len, input string name);
        logic [7:0] exp;
        tests++;
        if (bus.instr_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready0: instr_ready=%b expected 1", name, bus.instr_ready);
        end
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_addr  = 10'h2AA;
        bus.instr_len   = CNT_W'(len);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            bus.instr_valid = 1'b0;
            @(negedge clk);
            exp = (c == 1) ? 8'b0000_0101 : 8'b0000_0001;
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s cycle %0d: obs=%b expected %b", name, c, obs, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) exp_rows.push_back(N'(10'h100 + i));
        bus.instr_valid = 1'b1;
        bus.instr_op    = 2'b00;
        bus.instr_addr  = 10'h100;
        bus.instr_len   = 8'd8;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            bus.instr_valid = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 5) begin
                rst = 1'b0;
                exp_rows.delete();
            end
            @(negedge clk);
            case (c)
                1:       exp = 8'b1000_0010;
                2, 3, 4: exp = 8'b0011_0010;
                default: exp = 8'b0000_0001;
            endcase
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL abort cycle %0d: obs=%b expected %b", c, obs, exp);
            end
            if (c == 5) begin
                tests++;
                if (cur_row !== '0 || D !== '0) begin
                    fails++;
                    $display("FAIL abort regs: cur_row=%h D=%h expected 0", cur_row, D);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pim(10'h010, 4, 0, "pim_run");
        test_pim(10'h3FE, 3, 3, "wrap_stall");
        test_back_to_back();
        test_reject(2'b10, 4, "rej_op");
        test_reject(2'b00, 0, "rej_len0");
        test_abort();
        test_pim(10'h005, 2, 0, "post_abort");
        tests++;
        if (exp_rows.size() != 0) begin
            fails++;
            $display("FAIL row_sb_drain: %0d rows never strobed, expected 0", exp_rows.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
